timestamp_fifo_arbiter: RTL and testbench

Round-robin arbiter that merges the 32-bit output FIFOs of up to `N_CH` timestamp cores into one FIFO-style stream for the readout. It sits between the per-core `FIFO_READ/FIFO_EMPTY/FIFO_DATA` ports and the downstream readout FIFO, all on `BUS_CLK`. Each timestamp event is a pair of words: type `0x1` (bits 23–0) followed by type `0x2` (bits 47–24). The arbiter keeps the grant on one channel until the pair is complete, so the two words of an event are never interleaved with another channel's words.

---
 rtl/timestamp_arb_pkg.sv | 12 +
 rtl/timestamp_fifo_arbiter_rr.sv | 28 ++
 rtl/timestamp_fifo_arbiter.sv | 147 ++++++++++++++
 tb/tb_timestamp_fifo_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/timestamp_arb_pkg.sv
// Shared constants and types for the timestamp FIFO arbiter.
// Word-type codes live in bits [27:24] of each 32-bit word.
package timestamp_arb_pkg;
    localparam logic [3:0] TS_WORD_LO = 4'h1;
    localparam logic [3:0] TS_WORD_HI = 4'h2;
    localparam int         ERR_CNT_W  = 8;

    typedef enum logic {
        IDLE,
        LOCK
    } arb_state_e;
endpackage

// File: rtl/timestamp_fifo_arbiter_rr.sv
// Combinational round-robin picker: first request after last_i,
// wrapping modulo N_CH.
module rr_priority_select #(
    parameter int N_CH = 4,
    parameter int IW   = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req_i,
    input  logic [IW-1:0]   last_i,
    output logic [N_CH-1:0] gnt_o,
    output logic [IW-1:0]   idx_o
);
    logic [IW-1:0] cand;

    // Walk from lowest to highest priority so the nearest hit wins.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        cand  = '0;
        for (int k = N_CH; k >= 1; k--) begin
            cand = IW'((int'(last_i) + k) % N_CH);
            if (req_i[cand]) begin
                gnt_o       = '0;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end
endmodule

// File: rtl/timestamp_fifo_arbiter.sv
// Merges per-core timestamp FIFOs into one stream, holding the
// grant on a channel until its lo/hi word pair is complete.
module timestamp_fifo_arbiter
    import timestamp_arb_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                 BUS_CLK,
    input  logic                 BUS_RST_N,
    input  logic [N_CH-1:0]      CONF_EN,
    input  logic [N_CH-1:0]      IN_FIFO_EMPTY,
    input  logic [32*N_CH-1:0]   IN_FIFO_DATA,
    output logic [N_CH-1:0]      IN_FIFO_READ,
    input  logic                 OUT_FIFO_READ,
    output logic                 OUT_FIFO_EMPTY,
    output logic [31:0]          OUT_FIFO_DATA,
    output logic [N_CH-1:0]      GRANT,
    output logic [ERR_CNT_W-1:0] LOCK_ERR_CNT
);
    localparam int IW = $clog2(N_CH);

    arb_state_e           state_q, state_d;
    logic [IW-1:0]        owner_q, owner_d;
    logic [IW-1:0]        last_q, last_d;
    logic [7:0]           tmo_q, tmo_d;
    logic                 ov_q, ov_d;
    logic [31:0]          data_q, data_d;
    logic [N_CH-1:0]      grant_q, grant_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;

    logic [N_CH-1:0] elig, rr_gnt, sel, owner_oh;
    logic [IW-1:0]   rr_idx, pidx;
    logic            accept, pop, err_evt, locked;
    logic [31:0]     pword;
    logic [3:0]      wtype;

    rr_priority_select #(.N_CH(N_CH), .IW(IW)) u_rr (
        .req_i  (elig),
        .last_i (last_q),
        .gnt_o  (rr_gnt),
        .idx_o  (rr_idx)
    );

    assign locked       = (state_q == LOCK);
    assign elig         = CONF_EN & ~IN_FIFO_EMPTY;
    assign accept       = ~ov_q | OUT_FIFO_READ;
    assign owner_oh     = {{(N_CH-1){1'b0}}, 1'b1} << owner_q;
    assign sel          = locked ? owner_oh : rr_gnt;
    assign pidx         = locked ? owner_q : rr_idx;
    assign IN_FIFO_READ = sel & elig & {N_CH{accept}};
    assign pop          = |IN_FIFO_READ;
    assign wtype        = pword[27:24];

    // Mux out the word of the channel being served.
    always_comb begin
        pword = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (pidx == IW'(i)) pword = IN_FIFO_DATA[32*i +: 32];
        end
    end

    // Lock FSM, timeout, error counting and output register update.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        tmo_d   = tmo_q;
        ov_d    = ov_q;
        data_d  = data_q;
        grant_d = grant_q;
        err_evt = 1'b0;
        if (pop) begin
            ov_d   = 1'b1;
            data_d = pword;
        end else if (OUT_FIFO_READ) begin
            ov_d = 1'b0;
        end
        unique case (state_q)
            IDLE: begin
                if (pop && wtype == TS_WORD_LO) begin
                    state_d = LOCK;
                    owner_d = pidx;
                    grant_d = rr_gnt;
                    tmo_d   = '0;
                end else if (pop) begin
                    last_d = pidx;
                end
            end
            LOCK: begin
                if (!CONF_EN[owner_q]) begin
                    err_evt = 1'b1;
                    state_d = IDLE;
                end else if (pop && wtype == TS_WORD_HI) begin
                    state_d = IDLE;
                end else if (pop && wtype == TS_WORD_LO) begin
                    err_evt = 1'b1;
                    tmo_d   = '0;
                end else if (pop) begin
                    err_evt = 1'b1;
                    state_d = IDLE;
                end else if ({1'b0, tmo_q} + 9'd1 >= 9'(TIMEOUT)) begin
                    err_evt = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
                if (state_d == IDLE) begin
                    last_d  = owner_q;
                    grant_d = '0;
                    tmo_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        err_d = err_q;
        if (err_evt && err_q != '1) err_d = err_q + 1'b1;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge BUS_CLK) begin
        if (!BUS_RST_N) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= IW'(N_CH-1);
            tmo_q   <= '0;
            ov_q    <= 1'b0;
            data_q  <= '0;
            grant_q <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            tmo_q   <= tmo_d;
            ov_q    <= ov_d;
            data_q  <= data_d;
            grant_q <= grant_d;
            err_q   <= err_d;
        end
    end

    assign OUT_FIFO_EMPTY = ~ov_q;
    assign OUT_FIFO_DATA  = data_q;
    assign GRANT          = grant_q;
    assign LOCK_ERR_CNT   = err_q;
endmodule

// File: tb/tb_timestamp_fifo_arbiter.sv
// Self-checking bench: queue-backed input FIFOs and a behavioural
// model of the pairing/round-robin rules, plus directed scenarios.
module tb_timestamp_fifo_arbiter;
    localparam int N   = 4;
    localparam int TMO = 12;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] en, empty, rd_in, grant;
    logic [32*N-1:0] data;
    logic         ord, oempty;
    logic [31:0]  odata;
    logic [7:0]   errc;

    timestamp_fifo_arbiter #(.N_CH(N), .TIMEOUT(TMO)) dut (
        .BUS_CLK        (clk),
        .BUS_RST_N      (rst_n),
        .CONF_EN        (en),
        .IN_FIFO_EMPTY  (empty),
        .IN_FIFO_DATA   (data),
        .IN_FIFO_READ   (rd_in),
        .OUT_FIFO_READ  (ord),
        .OUT_FIFO_EMPTY (oempty),
        .OUT_FIFO_DATA  (odata),
        .GRANT          (grant),
        .LOCK_ERR_CNT   (errc)
    );

    always #5 clk = ~clk;

    logic [31:0] q [N][$];
    logic [31:0] outlog[$];
    int          outcyc[$];
    int          n_chk = 0, n_err = 0, cyc = 0, npop = 0;
    logic [N-1:0] last_rd;

    bit          m_locked, m_ov;
    int          m_owner, m_last, m_idle, m_err;
    logic [31:0] m_data;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mk(int ch, logic [3:0] t, int s);
        return {4'(ch), t, 24'(s)};
    endfunction

    task automatic model_reset();
        m_locked = 0; m_ov = 0; m_owner = 0;
        m_last = N-1; m_idle = 0; m_err = 0; m_data = '0;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            empty[i] = (q[i].size() == 0);
            data[32*i +: 32] = (q[i].size() != 0) ? q[i][0] : 32'h0;
        end
    endtask

    task automatic tick();
        logic [N-1:0] erd;
        logic [31:0]  w, g;
        int  pick;
        bit  acc, pop, err;
        drive();
        @(negedge clk);
        cyc++;
        erd = '0; pick = -1;
        acc = !m_ov || ord;
        if (m_locked) begin
            if (en[m_owner] && q[m_owner].size() > 0) pick = m_owner;
        end else begin
            for (int j = 1; j <= N; j++) begin
                int c;
                c = (m_last + j) % N;
                if (pick < 0 && en[c] && q[c].size() > 0) pick = c;
            end
        end
        pop = (pick >= 0) && acc;
        if (pop) erd[pick] = 1'b1;
        chk("in_read", 32'(rd_in), 32'(erd));
        chk("out_empty", 32'(oempty), 32'(!m_ov));
        if (m_ov) chk("out_data", odata, m_data);
        g = m_locked ? (32'd1 << m_owner) : 32'd0;
        chk("grant", 32'(grant), g);
        chk("err_cnt", 32'(errc), 32'(m_err));
        npop += $countones(rd_in);
        last_rd = rd_in;
        if (rst_n && !oempty && ord) begin
            outlog.push_back(odata);
            outcyc.push_back(cyc);
        end
        if (!rst_n) begin
            model_reset();
        end else begin
            err = 0;
            if (pop) begin
                w = q[pick].pop_front();
                m_ov = 1; m_data = w;
                if (!m_locked) begin
                    if (w[27:24] == 4'h1) begin
                        m_locked = 1; m_owner = pick; m_idle = 0;
                    end else m_last = pick;
                end else if (w[27:24] == 4'h2) begin
                    m_locked = 0; m_last = m_owner;
                end else if (w[27:24] == 4'h1) begin
                    err = 1; m_idle = 0;
                end else begin
                    err = 1; m_locked = 0; m_last = m_owner;
                end
            end else begin
                if (ord) m_ov = 0;
                if (m_locked) begin
                    if (!en[m_owner]) begin
                        err = 1; m_locked = 0; m_last = m_owner;
                    end else begin
                        m_idle++;
                        if (m_idle >= TMO) begin
                            err = 1; m_locked = 0;
                            m_last = m_owner; m_idle = 0;
                        end
                    end
                end
            end
            if (err && m_err < 255) m_err++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        en = '0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) q[i].delete();
        outlog.delete();
        outcyc.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; en = '0; ord = 1'b1;
        model_reset();
        clear_all();
        reset_dut();
        chk("rst_empty", 32'(oempty), 32'd1);
        chk("rst_data", odata, 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_err", 32'(errc), 32'd0);

        // two channels, back-to-back pairs
        clear_all(); reset_dut();
        en = 4'b0011;
        q[0] = '{mk(0, 1, 'hA0), mk(0, 2, 'hB0)};
        q[1] = '{mk(1, 1, 'hA1), mk(1, 2, 'hB1)};
        repeat (6) tick();
        chk("t1_cnt", 32'(outlog.size()), 32'd4);
        chk("t1_w0", outlog[0], mk(0, 1, 'hA0));
        chk("t1_w1", outlog[1], mk(0, 2, 'hB0));
        chk("t1_w2", outlog[2], mk(1, 1, 'hA1));
        chk("t1_w3", outlog[3], mk(1, 2, 'hB1));
        chk("t1_span", 32'(outcyc[3] - outcyc[0]), 32'd3);
        chk("t1_err", 32'(errc), 32'd0);

        // ch1 waits for hi while ch2 has full pairs
        clear_all(); reset_dut();
        en = 4'b0110;
        q[1] = '{mk(1, 1, 'h11)};
        q[2] = '{mk(2, 1, 1), mk(2, 2, 2), mk(2, 1, 3), mk(2, 2, 4)};
        tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t2_grant", 32'(grant), 32'h2);
        end
        q[1].push_back(mk(1, 2, 'h12));
        repeat (8) tick();
        chk("t2_lo", outlog[0], mk(1, 1, 'h11));
        chk("t2_hi", outlog[1], mk(1, 2, 'h12));
        chk("t2_cnt", 32'(outlog.size()), 32'd6);

        // lone lo word times out
        clear_all(); reset_dut();
        en = 4'b0011;
        q[0] = '{mk(0, 1, 'h55)};
        q[1] = '{mk(1, 1, 'h66), mk(1, 2, 'h67)};
        tick();
        repeat (TMO - 1) tick();
        chk("t3_held", 32'(grant), 32'h1);
        tick();
        chk("t3_rel", 32'(grant), 32'h0);
        chk("t3_err", 32'(errc), 32'd1);
        tick();
        chk("t3_next", 32'(grant), 32'h2);
        repeat (3) tick();

        // lo, lo, hi on ch0
        clear_all(); reset_dut();
        en = 4'b0001;
        q[0] = '{mk(0, 1, 1), mk(0, 1, 2), mk(0, 2, 3)};
        repeat (4) tick();
        chk("t4_err", 32'(errc), 32'd1);
        chk("t4_grant", 32'(grant), 32'h0);
        chk("t4_cnt", 32'(outlog.size()), 32'd3);

        // downstream stall with all channels full
        clear_all(); reset_dut();
        en = 4'b1111;
        for (int i = 0; i < N; i++)
            for (int p = 0; p < 2; p++) begin
                q[i].push_back(mk(i, 1, 2*p));
                q[i].push_back(mk(i, 2, 2*p+1));
            end
        ord = 1'b0; npop = 0;
        repeat (5) tick();
        chk("t5_pops", 32'(npop), 32'd1);
        chk("t5_data", odata, mk(0, 1, 0));
        chk("t5_valid", 32'(oempty), 32'd0);
        ord = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (q[0].size() + q[1].size() + q[2].size()
                + q[3].size() == 0 && !m_ov) break;
            tick();
        end
        chk("t5_cnt", 32'(outlog.size()), 32'd16);

        // reset mid-pair with error count nonzero
        clear_all(); reset_dut();
        en = 4'b0001;
        q[0] = '{mk(0, 1, 1), mk(0, 2, 2), mk(0, 1, 3), mk(0, 1, 4)};
        repeat (4) tick();
        chk("t6_pre_err", 32'(errc), 32'd1);
        en = 4'b0011;
        q[1] = '{mk(1, 1, 5), mk(1, 2, 6)};
        tick();
        reset_dut();
        chk("t6_empty", 32'(oempty), 32'd1);
        chk("t6_grant", 32'(grant), 32'd0);
        chk("t6_err", 32'(errc), 32'd0);
        en = 4'b0011;
        q[0].push_back(mk(0, 1, 7));
        q[0].push_back(mk(0, 2, 8));
        tick();
        chk("t6_first", 32'(last_rd), 32'h1);
        repeat (6) tick();

        // randomized traffic
        clear_all(); reset_dut();
        for (int c = 0; c < 1500; c++) begin
            en = 4'hF;
            if ($urandom_range(0, 49) == 0)
                en[$urandom_range(0, N-1)] = 1'b0;
            ord = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (q[i].size() < 6 && $urandom_range(0, 3) == 0) begin
                    int r, s;
                    r = $urandom_range(0, 15);
                    s = $urandom_range(0, 'hFFFF);
                    if (r < 12) begin
                        q[i].push_back(mk(i, 1, s));
                        q[i].push_back(mk(i, 2, s));
                    end else if (r == 12) q[i].push_back(mk(i, 1, s));
                    else if (r == 13) q[i].push_back(mk(i, 2, s));
                    else if (r == 14) q[i].push_back(mk(i, 3, s));
                    else begin
                        q[i].push_back(mk(i, 1, s));
                        q[i].push_back(mk(i, 1, s));
                        q[i].push_back(mk(i, 2, s));
                    end
                end
            end
            tick();
        end
        en = 4'hF; ord = 1'b1;
        repeat (200) tick();
        chk("drain", 32'(q[0].size() + q[1].size()
            + q[2].size() + q[3].size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
